// File: rtl/onehot_ring_monitor.sv
// Tracks a one-hot ring counter: binary index, lap count, stall and sticky fault flags.
// Optional macro ONEHOT_RECOVER_EN lets a legal sample pull FAULT back into TRACK.
module onehot_ring_monitor #(
    parameter int WIDTH       = 3,
    parameter int IDXW        = 2,
    parameter int LAPW        = 4,
    parameter int STALL_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  index,
    output logic             valid,
    output logic [LAPW-1:0]  laps,
    output logic             stall,
    output logic             code_err,
    output logic             step_err
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [IDXW-1:0] pos_of(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) p = IDXW'(i);
        return p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] h);
        return (h >= LIMIT) ? LIMIT : h + 8'd1;
    endfunction

    state_t           state_p0, state_nx;
    logic [WIDTH-1:0] prev_p0, prev_nx;
    logic [IDXW-1:0]  index_p0, index_nx;
    logic [LAPW-1:0]  laps_p0, laps_nx;
    logic [7:0]       hold_p0, hold_nx;
    logic             stall_p0, stall_nx;
    logic             vld_p0, vld_nx;
    logic             code_err_p0, code_err_nx;
    logic             step_err_p0, step_err_nx;

    logic             legal;
    logic [IDXW-1:0]  pos;
    logic [WIDTH-1:0] rot;
    logic [7:0]       hold_inc;

    assign legal    = is_legal(onehot);
    assign pos      = pos_of(onehot);
    assign rot      = {prev_p0[WIDTH-2:0], prev_p0[WIDTH-1]};
    assign hold_inc = sat_inc(hold_p0);

    always_comb begin
        state_nx    = state_p0;
        prev_nx     = prev_p0;
        index_nx    = index_p0;
        laps_nx     = laps_p0;
        hold_nx     = hold_p0;
        stall_nx    = stall_p0;
        vld_nx      = vld_p0;
        code_err_nx = code_err_p0;
        step_err_nx = step_err_p0;
        if (enable) begin
            case (state_p0)
                IDLE: begin
                    if (legal) begin
                        state_nx = TRACK;
                        prev_nx  = onehot;
                        index_nx = pos;
                        vld_nx   = 1'b1;
                        hold_nx  = '0;
                        stall_nx = 1'b0;
                    end
                end
                TRACK: begin
                    // Illegal codes are tested first so code_err and step_err never fire together.
                    if (!legal) begin
                        code_err_nx = 1'b1;
                        vld_nx      = 1'b0;
                        state_nx    = FAULT;
                    end else if (onehot == prev_p0) begin
                        hold_nx  = hold_inc;
                        stall_nx = (hold_inc == LIMIT);
                    end else if (onehot == rot) begin
                        prev_nx  = onehot;
                        index_nx = pos;
                        hold_nx  = '0;
                        stall_nx = 1'b0;
                        if (prev_p0[WIDTH-1]) laps_nx = laps_p0 + 1'b1;
                    end else begin
                        step_err_nx = 1'b1;
                        vld_nx      = 1'b0;
                        state_nx    = FAULT;
                    end
                end
                FAULT: begin
`ifdef ONEHOT_RECOVER_EN
                    if (legal) begin
                        state_nx = TRACK;
                        prev_nx  = onehot;
                        index_nx = pos;
                        vld_nx   = 1'b1;
                        hold_nx  = '0;
                        stall_nx = 1'b0;
                    end
`endif
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output/state register stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0    <= IDLE;
            prev_p0     <= '0;
            index_p0    <= '0;
            laps_p0     <= '0;
            hold_p0     <= '0;
            stall_p0    <= 1'b0;
            vld_p0      <= 1'b0;
            code_err_p0 <= 1'b0;
            step_err_p0 <= 1'b0;
        end else begin
            state_p0    <= state_nx;
            prev_p0     <= prev_nx;
            index_p0    <= index_nx;
            laps_p0     <= laps_nx;
            hold_p0     <= hold_nx;
            stall_p0    <= stall_nx;
            vld_p0      <= vld_nx;
            code_err_p0 <= code_err_nx;
            step_err_p0 <= step_err_nx;
        end
    end

    assign index    = index_p0;
    assign valid    = vld_p0;
    assign laps     = laps_p0;
    assign stall    = stall_p0;
    assign code_err = code_err_p0;
    assign step_err = step_err_p0;

endmodule

// File: tb/tb_onehot_ring_monitor.sv
// Randomized bench for onehot_ring_monitor with a position-arithmetic reference model.
module tb_onehot_ring_monitor;

    localparam int W     = 3;
    localparam int IW    = 2;
    localparam int LW    = 4;
    localparam int LIMIT = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  onehot = '0;
    logic [IW-1:0] index;
    logic          valid;
    logic [LW-1:0] laps;
    logic          stall;
    logic          code_err;
    logic          step_err;

    onehot_ring_monitor #(.WIDTH(W), .IDXW(IW), .LAPW(LW), .STALL_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .onehot(onehot),
        .index(index), .valid(valid), .laps(laps), .stall(stall),
        .code_err(code_err), .step_err(step_err)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0=idle 1=tracking 2=faulted, position held as an integer
    int m_mode = 0, m_idx = 0, m_laps = 0, m_hold = 0;
    bit m_valid = 0, m_stall = 0, m_cerr = 0, m_serr = 0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;

    string lq_name[$];
    int    lq_sel[$];
    int    lq_exp[$];

    function automatic int low_pos(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_update();
        int ones, p;
        if (reset) begin
            m_mode = 0; m_idx = 0; m_laps = 0; m_hold = 0;
            m_valid = 0; m_stall = 0; m_cerr = 0; m_serr = 0;
        end else if (enable) begin
            ones = $countones(onehot);
            p    = low_pos(onehot);
            if (m_mode == 0) begin
                if (ones == 1) begin
                    m_mode = 1; m_idx = p; m_valid = 1; m_hold = 0; m_stall = 0;
                end
            end else if (m_mode == 1) begin
                if (ones != 1) begin
                    m_cerr = 1; m_valid = 0; m_mode = 2;
                end else if (p == m_idx) begin
                    m_hold  = (m_hold + 1 > LIMIT) ? LIMIT : m_hold + 1;
                    m_stall = (m_hold == LIMIT);
                end else if (p == (m_idx + 1) % W) begin
                    if (m_idx == W - 1) m_laps = (m_laps + 1) % (1 << LW);
                    m_idx = p; m_hold = 0; m_stall = 0;
                end else begin
                    m_serr = 1; m_valid = 0; m_mode = 2;
                end
            end else begin
`ifdef ONEHOT_RECOVER_EN
                if (ones == 1) begin
                    m_mode = 1; m_idx = p; m_valid = 1; m_hold = 0; m_stall = 0;
                end
`endif
            end
        end
    endtask

    function automatic int field(input int sel);
        case (sel)
            0: return int'(index);
            1: return int'(valid);
            2: return int'(laps);
            3: return int'(stall);
            4: return int'(code_err);
            default: return int'(step_err);
        endcase
    endfunction

    // Single compare process: whole-output check each cycle, then queued literal checks
    always @(negedge clock) begin
        logic [9:0] got, exp;
        if (chk_on) begin
            got = {index, valid, laps, stall, code_err, step_err};
            exp = {IW'(m_idx), m_valid, LW'(m_laps), m_stall, m_cerr, m_serr};
            n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL outputs t=%0t got idx=%0d vld=%0d laps=%0d stall=%0d cerr=%0d serr=%0d want idx=%0d vld=%0d laps=%0d stall=%0d cerr=%0d serr=%0d",
                          $time, index, valid, laps, stall, code_err, step_err,
                          m_idx, m_valid, m_laps, m_stall, m_cerr, m_serr);
        end
        while (lq_name.size() > 0) begin
            string nm;
            int sel, e, g;
            nm = lq_name.pop_front();
            sel = lq_sel.pop_front();
            e = lq_exp.pop_front();
            g = field(sel);
            n_checks++;
            if (g == e) n_pass++;
            else $display("FAIL %s got %0d want %0d", nm, g, e);
        end
    end

    task automatic lit(input string nm, input int sel, input int v);
        lq_name.push_back(nm);
        lq_sel.push_back(sel);
        lq_exp.push_back(v);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [W-1:0] oh);
        @(negedge clock);
        reset = r; enable = e; onehot = oh;
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, '0);
    endtask

    initial begin
        logic [W-1:0] oh;
        int hold_pct;
        logic e, r;

        do_reset();
        chk_on = 1;
        do_reset();
        lit("rst_index", 0, 0); lit("rst_valid", 1, 0); lit("rst_laps", 2, 0);
        lit("rst_stall", 3, 0); lit("rst_cerr", 4, 0);  lit("rst_serr", 5, 0);

        // Basic sequence
        cyc(0, 1, 3'b001); lit("basic_idx0", 0, 0); lit("basic_vld0", 1, 1);
        cyc(0, 1, 3'b010); lit("basic_idx1", 0, 1);
        cyc(0, 1, 3'b100); lit("basic_idx2", 0, 2); lit("basic_laps2", 2, 0);
        cyc(0, 1, 3'b001); lit("basic_idx3", 0, 0); lit("basic_laps3", 2, 1);

        // Lap wrap
        do_reset();
        for (int i = 0; i < 49; i++) begin
            cyc(0, 1, W'(1 << (i % W)));
            if (i == 45) lit("lap15", 2, 15);
            if (i == 48) begin lit("lap_wrap", 2, 0); lit("lap_noerr", 5, 0); end
        end

        // Illegal code
        do_reset();
        cyc(0, 1, 3'b001);
        cyc(0, 1, 3'b011); lit("code_err", 4, 1); lit("code_vld", 1, 0); lit("code_idx", 0, 0);
        cyc(0, 1, 3'b010);
`ifdef ONEHOT_RECOVER_EN
        lit("recover_idx", 0, 1); lit("recover_vld", 1, 1);
`else
        lit("fault_idx", 0, 0); lit("fault_vld", 1, 0);
`endif
        lit("code_sticky", 4, 1);

        // Illegal step
        do_reset();
        cyc(0, 1, 3'b001); cyc(0, 1, 3'b010);
        cyc(0, 1, 3'b001);
        lit("step_err", 5, 1); lit("step_vld", 1, 0); lit("step_idx", 0, 1);
        lit("step_laps", 2, 0); lit("step_nocerr", 4, 0);

        // Stall, with an enable=0 gap that must not advance the hold count
        do_reset();
        for (int i = 0; i < 8; i++) cyc(0, 1, 3'b010);
        lit("stall_pre", 3, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 3'b010);
        lit("stall_gap", 3, 0);
        cyc(0, 1, 3'b010); lit("stall_set", 3, 1);
        cyc(0, 1, 3'b100); lit("stall_clr", 3, 0); lit("stall_idx", 0, 2);

        // Reset priority
        cyc(1, 1, 3'b000);
        cyc(0, 1, 3'b000); cyc(0, 1, 3'b000); lit("idle_zero_vld", 1, 0);
        cyc(0, 1, 3'b001); lit("idle_acc_vld", 1, 1); lit("idle_acc_idx", 0, 0);
        for (int i = 1; i <= 9; i++) cyc(0, 1, W'(1 << (i % W)));
        lit("mid_laps3", 2, 3);
        cyc(1, 1, 3'b010); lit("mid_rst_laps", 2, 0); lit("mid_rst_vld", 1, 0);

        // Randomized traffic
        hold_pct = 10;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) hold_pct = ($urandom_range(0, 1) == 0) ? 10 : 85;
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < hold_pct) oh = W'(1 << m_idx);
            else begin
                case ($urandom_range(0, 19))
                    0: case ($urandom_range(0, 4))
                           0: oh = 3'b000; 1: oh = 3'b011; 2: oh = 3'b101;
                           3: oh = 3'b110; default: oh = 3'b111;
                       endcase
                    1: oh = W'(1 << $urandom_range(0, W - 1));
                    default: oh = W'(1 << ((m_idx + 1) % W));
                endcase
            end
            cyc(r, e, oh);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
